// File: rtl/rd_arbiter_pkg.sv
// Shared definitions for the read-channel arbiter.
// Holds the tenure FSM encoding, the default arbiter sizing and the counter widths.
package rd_arbiter_pkg;

  // Tenure FSM encoding
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StBusy    = 2'd1,
    StDrain   = 2'd2,
    StRelease = 2'd3
  } rd_state_e;

  // Default sizing
  localparam int unsigned NumMDefault      = 4;
  localparam int unsigned MaxOutsDefault   = 4;
  localparam int unsigned MaxBurstsDefault = 8;

  // Counter widths: out_cnt must hold MaxOuts, burst_cnt must hold MaxBursts
  localparam int unsigned OutCntW   = 3;
  localparam int unsigned BurstCntW = 4;

endpackage

// File: rtl/rd_arbiter_rr_pick.sv
// Round-robin priority select.
// Combinational: returns the first set request bit at or above ptr, wrapping past
// NUM_REQ-1 back to 0.
//   req  in   NUM_REQ  request vector
//   ptr  in   IDX_W    highest-priority position
//   gnt  out  NUM_REQ  one-hot selection, all-zero when req is zero
//   idx  out  IDX_W    binary index of the selection, 0 when req is zero
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin
    logic        found;
    int unsigned pos;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      pos = (32'(ptr) + off) % NUM_REQ;
      if (!found && req[pos[IDX_W-1:0]]) begin
        found                 = 1'b1;
        gnt[pos[IDX_W-1:0]]   = 1'b1;
        idx                   = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/rd_arbiter.sv
// Read-channel request arbiter.
// Grants one master by round robin, holds the grant while its reads are outstanding,
// and pulses rd_state_refre at the end of the tenure to clear the downstream address
// register stage.
//   sys_clk, sys_rstn   clock, asynchronous active-low reset
//   s_arvalid           per-master AR valid
//   m_arready           AR ready from the selected slave
//   s_rready            R ready of the granted master
//   m_rvalid, m_rlast   R valid/last from the selected slave
//   rd_reg_flag         downstream stage already has more than one burst outstanding
//   rd_grant            one-hot grant (zero when idle)
//   rd_grant_idx        binary index of the grant
//   rd_grant_vld        grant active
//   ar_gate             lets the granted s_arvalid through to the slave
//   rd_state_refre      one-cycle end-of-tenure pulse
module rd_arbiter
  import rd_arbiter_pkg::*;
#(
  parameter int unsigned NUM_M      = NumMDefault,
  parameter int unsigned IDX_W      = 2,
  parameter int unsigned MAX_OUTS   = MaxOutsDefault,
  parameter int unsigned MAX_BURSTS = MaxBurstsDefault
) (
  input  logic             sys_clk,
  input  logic             sys_rstn,
  input  logic [NUM_M-1:0] s_arvalid,
  input  logic             m_arready,
  input  logic             s_rready,
  input  logic             m_rvalid,
  input  logic             m_rlast,
  input  logic             rd_reg_flag,
  output logic [NUM_M-1:0] rd_grant,
  output logic [IDX_W-1:0] rd_grant_idx,
  output logic             rd_grant_vld,
  output logic             ar_gate,
  output logic             rd_state_refre
);

  localparam logic [OutCntW-1:0]   MaxOutsC   = OutCntW'(MAX_OUTS);
  localparam logic [BurstCntW-1:0] MaxBurstsC = BurstCntW'(MAX_BURSTS);
  localparam logic [IDX_W-1:0]     LastIdx    = IDX_W'(NUM_M - 1);

  rd_state_e             state_q;
  logic [OutCntW-1:0]    out_cnt_q, out_cnt_d;
  logic [BurstCntW-1:0]  burst_cnt_q, burst_cnt_d;
  logic [IDX_W-1:0]      rr_ptr_q;

  logic [NUM_M-1:0]      pick_gnt;
  logic [IDX_W-1:0]      pick_idx;
  logic                  ar_hs, r_done, r_dec, tenure_end;

  rr_pick #(
    .NUM_REQ (NUM_M),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req (s_arvalid),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  always_comb begin
    ar_gate = (state_q == StBusy) & ~rd_reg_flag & (out_cnt_q < MaxOutsC) &
              (burst_cnt_q < MaxBurstsC);
    ar_hs   = s_arvalid[rd_grant_idx] & ar_gate & m_arready & rd_grant_vld;
    r_done  = m_rvalid & s_rready & m_rlast & rd_grant_vld;
    // An rlast with nothing outstanding is a protocol error; never underflow.
    r_dec   = r_done & (out_cnt_q != '0);

    out_cnt_d = out_cnt_q;
    if (ar_hs && !r_dec) begin
      if (out_cnt_q != MaxOutsC) out_cnt_d = out_cnt_q + 1'b1;
    end else if (!ar_hs && r_dec) begin
      out_cnt_d = out_cnt_q - 1'b1;
    end

    burst_cnt_d = burst_cnt_q;
    if (ar_hs && (burst_cnt_q != MaxBurstsC)) burst_cnt_d = burst_cnt_q + 1'b1;

    // Master stopped requesting, or it has used up its fairness budget.
    tenure_end = ~s_arvalid[rd_grant_idx] | (burst_cnt_q == MaxBurstsC);
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q        <= StIdle;
      rr_ptr_q       <= '0;
      out_cnt_q      <= '0;
      burst_cnt_q    <= '0;
      rd_grant       <= '0;
      rd_grant_idx   <= '0;
      rd_grant_vld   <= 1'b0;
      rd_state_refre <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (|s_arvalid) begin
            rd_grant     <= pick_gnt;
            rd_grant_idx <= pick_idx;
            rd_grant_vld <= 1'b1;
            out_cnt_q    <= '0;
            burst_cnt_q  <= '0;
            state_q      <= StBusy;
          end
        end
        StBusy: begin
          out_cnt_q   <= out_cnt_d;
          burst_cnt_q <= burst_cnt_d;
          if (tenure_end) begin
            if (out_cnt_d == '0) begin
              state_q        <= StRelease;
              rd_state_refre <= 1'b1;
            end else begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          out_cnt_q <= out_cnt_d;
          if (out_cnt_d == '0) begin
            state_q        <= StRelease;
            rd_state_refre <= 1'b1;
          end
        end
        StRelease: begin
          rd_state_refre <= 1'b0;
          rd_grant       <= '0;
          rd_grant_idx   <= '0;
          rd_grant_vld   <= 1'b0;
          rr_ptr_q       <= (rd_grant_idx == LastIdx) ? '0 : rd_grant_idx + 1'b1;
          state_q        <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // R completion with no read outstanding.
  a_no_r_underflow : assert property (@(posedge sys_clk) disable iff (!sys_rstn)
    !(r_done && (out_cnt_q == '0)));

  // Grant vector always matches the index/valid pair.
  a_grant_onehot : assert property (@(posedge sys_clk) disable iff (!sys_rstn)
    rd_grant == (rd_grant_vld ? (NUM_M'(1) << rd_grant_idx) : '0));

endmodule

// File: tb/tb_rd_arbiter.sv
module tb_rd_arbiter;

  logic       sys_clk;
  logic       sys_rstn;
  logic [3:0] s_arvalid;
  logic       m_arready;
  logic       s_rready;
  logic       m_rvalid;
  logic       m_rlast;
  logic       rd_reg_flag;
  logic [3:0] rd_grant;
  logic [1:0] rd_grant_idx;
  logic       rd_grant_vld;
  logic       ar_gate;
  logic       rd_state_refre;

  int checks = 0;
  int errors = 0;
  int hs_cnt;

  rd_arbiter dut (
    .sys_clk        (sys_clk),
    .sys_rstn       (sys_rstn),
    .s_arvalid      (s_arvalid),
    .m_arready      (m_arready),
    .s_rready       (s_rready),
    .m_rvalid       (m_rvalid),
    .m_rlast        (m_rlast),
    .rd_reg_flag    (rd_reg_flag),
    .rd_grant       (rd_grant),
    .rd_grant_idx   (rd_grant_idx),
    .rd_grant_vld   (rd_grant_vld),
    .ar_gate        (ar_gate),
    .rd_state_refre (rd_state_refre)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_grant(input string tag, input logic vld, input int idx);
    logic [3:0] exp_gnt;
    exp_gnt = vld ? (4'b0001 << idx) : 4'b0000;
    chk({tag, "_vld"}, 32'(rd_grant_vld), 32'(vld));
    chk({tag, "_idx"}, 32'(rd_grant_idx), vld ? 32'(idx) : 32'd0);
    chk({tag, "_gnt"}, 32'(rd_grant), 32'(exp_gnt));
  endtask

  // Entered with master idx freshly granted and all masters requesting: one AR,
  // then arvalid drops together with the only rlast.
  task automatic one_burst(input int idx);
    chk_grant($sformatf("rr_grant%0d", idx), 1'b1, idx);
    m_arready = 1'b1;
    tick();
    m_arready      = 1'b0;
    s_arvalid[idx] = 1'b0;
    m_rvalid       = 1'b1;
    m_rlast        = 1'b1;
    tick();
    chk($sformatf("rr_refre%0d", idx), 32'(rd_state_refre), 32'd1);
    chk_grant($sformatf("rr_hold%0d", idx), 1'b1, idx);
    m_rvalid       = 1'b0;
    m_rlast        = 1'b0;
    s_arvalid[idx] = 1'b1;
    tick();
    chk($sformatf("rr_refre_off%0d", idx), 32'(rd_state_refre), 32'd0);
    chk($sformatf("rr_idle_vld%0d", idx), 32'(rd_grant_vld), 32'd0);
    tick();
  endtask

  initial begin
    sys_rstn    = 1'b0;
    s_arvalid   = 4'b0000;
    m_arready   = 1'b0;
    s_rready    = 1'b1;
    m_rvalid    = 1'b0;
    m_rlast     = 1'b0;
    rd_reg_flag = 1'b0;

    // Reset state
    #12;
    chk_grant("rst", 1'b0, 0);
    chk("rst_gate", 32'(ar_gate), 32'd0);
    chk("rst_refre", 32'(rd_state_refre), 32'd0);
    sys_rstn = 1'b1;
    tick();
    chk("idle_noreq", 32'(rd_grant_vld), 32'd0);

    // Single master 2
    s_arvalid = 4'b0100;
    m_arready = 1'b1;
    tick();
    chk_grant("single_grant", 1'b1, 2);
    chk("single_gate", 32'(ar_gate), 32'd1);
    tick();
    s_arvalid = 4'b0000;
    m_arready = 1'b0;
    tick();
    chk("drain_gate", 32'(ar_gate), 32'd0);
    chk("drain_refre", 32'(rd_state_refre), 32'd0);
    chk_grant("drain_hold", 1'b1, 2);
    m_rvalid = 1'b1;
    m_rlast  = 1'b1;
    tick();
    chk("single_refre", 32'(rd_state_refre), 32'd1);
    chk("single_rel_gate", 32'(ar_gate), 32'd0);
    chk_grant("single_rel", 1'b1, 2);
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    tick();
    chk("single_refre_off", 32'(rd_state_refre), 32'd0);
    chk_grant("single_idle", 1'b0, 0);

    // Round robin: rr_ptr is 3 now, so order is 3,0,1,2,3 then 0
    s_arvalid = 4'b1111;
    tick();
    one_burst(3);
    one_burst(0);
    one_burst(1);
    one_burst(2);
    one_burst(3);
    chk_grant("rr_wrap", 1'b1, 0);

    // Outstanding gating with master 0
    s_arvalid = 4'b0001;
    m_arready = 1'b1;
    #1;
    chk("og_gate0", 32'(ar_gate), 32'd1);
    tick();
    tick();
    rd_reg_flag = 1'b1;
    #1;
    chk("og_flag_gate", 32'(ar_gate), 32'd0);
    rd_reg_flag = 1'b0;
    #1;
    chk("og_noflag_gate", 32'(ar_gate), 32'd1);
    tick();
    tick();
    #1;
    chk("og_max_gate", 32'(ar_gate), 32'd0);
    s_arvalid = 4'b0000;
    m_arready = 1'b0;
    m_rvalid  = 1'b1;
    m_rlast   = 1'b1;
    tick();
    chk("og_r1_refre", 32'(rd_state_refre), 32'd0);
    chk("og_r1_vld", 32'(rd_grant_vld), 32'd1);
    tick();
    tick();
    chk("og_r3_refre", 32'(rd_state_refre), 32'd0);
    tick();
    chk("og_r4_refre", 32'(rd_state_refre), 32'd1);
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    tick();
    chk("og_idle", 32'(rd_grant_vld), 32'd0);

    // Fairness cap: master 1 streams, master 3 waits
    s_arvalid = 4'b1010;
    tick();
    chk_grant("fair_grant", 1'b1, 1);
    m_arready = 1'b1;
    hs_cnt    = 0;
    for (int i = 0; i < 8; i++) begin
      m_rvalid = (i != 0);
      m_rlast  = (i != 0);
      #1;
      if (ar_gate) hs_cnt++;
      tick();
    end
    m_rvalid = 1'b1;
    m_rlast  = 1'b1;
    #1;
    chk("fair_cap_gate", 32'(ar_gate), 32'd0);
    chk("fair_hs_cnt", 32'(hs_cnt), 32'd8);
    tick();
    chk("fair_refre", 32'(rd_state_refre), 32'd1);
    chk_grant("fair_rel", 1'b1, 1);
    m_rvalid  = 1'b0;
    m_rlast   = 1'b0;
    m_arready = 1'b0;
    tick();
    tick();
    chk_grant("fair_next", 1'b1, 3);

    // Simultaneous AR handshake and rlast with out_cnt=1
    s_arvalid = 4'b1000;
    m_arready = 1'b1;
    tick();
    m_rvalid = 1'b1;
    m_rlast  = 1'b1;
    #1;
    chk("sim_gate", 32'(ar_gate), 32'd1);
    tick();
    chk("sim_refre", 32'(rd_state_refre), 32'd0);
    chk("sim_vld", 32'(rd_grant_vld), 32'd1);
    s_arvalid = 4'b0000;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rlast   = 1'b0;
    tick();
    chk("sim_drain_refre", 32'(rd_state_refre), 32'd0);
    chk("sim_drain_vld", 32'(rd_grant_vld), 32'd1);
    m_rvalid = 1'b1;
    m_rlast  = 1'b1;
    tick();
    chk("sim_refre_end", 32'(rd_state_refre), 32'd1);
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    tick();
    chk("sim_idle", 32'(rd_grant_vld), 32'd0);

    // Reset in the middle of a tenure with two reads outstanding
    s_arvalid = 4'b0100;
    m_arready = 1'b1;
    tick();
    chk_grant("mr_grant", 1'b1, 2);
    tick();
    tick();
    #3;
    sys_rstn = 1'b0;
    #1;
    chk_grant("mr_async", 1'b0, 0);
    chk("mr_gate", 32'(ar_gate), 32'd0);
    chk("mr_refre", 32'(rd_state_refre), 32'd0);
    s_arvalid = 4'b0000;
    m_arready = 1'b0;
    tick();
    chk("mr_refre_held", 32'(rd_state_refre), 32'd0);
    sys_rstn = 1'b1;
    tick();
    chk("mr_idle_vld", 32'(rd_grant_vld), 32'd0);
    chk("mr_idle_refre", 32'(rd_state_refre), 32'd0);
    s_arvalid = 4'b1001;
    tick();
    chk_grant("mr_regrant", 1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
